// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// seven_seg_scan : 4-digit multiplexed 7-segment driver, scan paced by clk_1khz
// Optional: SEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1.
// Rev 1.0
// ============================================================================
module seven_seg_scan #(
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_1khz,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_BLANK   = 2'd1;
  localparam logic [1:0]  ST_SHOW    = 2'd2;
  localparam logic [15:0] BLANK_LOAD = 16'(BLANK_CYCLES - 1);

  logic        sync1, sync2, prev, tick;
  logic [1:0]  state, state_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [15:0] shadow, shadow_nxt;
  logic [3:0]  shadow_dp, shadow_dp_nxt;
  logic [3:0]  an_nxt;
  logic [3:0]  nibble;
  logic        blank_digit;
  logic [6:0]  seg_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // clk_1khz is a data input: two-flop synchronizer plus edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= clk_1khz;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign tick = sync2 & ~prev;

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    idx_nxt       = idx;
    shadow_nxt    = shadow;
    shadow_dp_nxt = shadow_dp;
    if (tick) begin
      idx_nxt   = idx + 2'd1;
      state_nxt = ST_BLANK;
      cnt_nxt   = BLANK_LOAD;
      if (idx == 2'd3) begin
        shadow_nxt    = value;
        shadow_dp_nxt = dp_in;
      end
    end else begin
      case (state)
        ST_IDLE, ST_SHOW: state_nxt = state;
        ST_BLANK: begin
          if (cnt == 16'd0) state_nxt = ST_SHOW;
          else              cnt_nxt   = cnt - 16'd1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    an_nxt = (state_nxt == ST_SHOW && en) ? ~(4'b0001 << idx_nxt) : 4'b1111;
  end

  always_comb begin
    case (idx_nxt)
      2'd1:    nibble = shadow_nxt[7:4];
      2'd2:    nibble = shadow_nxt[11:8];
      2'd3:    nibble = shadow_nxt[15:12];
      default: nibble = shadow_nxt[3:0];
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx_nxt)
      2'd3:    blank_digit = (shadow_nxt[15:12] == 4'd0);
      2'd2:    blank_digit = (shadow_nxt[15:8]  == 8'd0);
      2'd1:    blank_digit = (shadow_nxt[15:4]  == 12'd0);
      default: blank_digit = 1'b0;
    endcase
  end
`else
  assign blank_digit = 1'b0;
`endif

  assign seg_nxt = blank_digit ? 7'b1111111 : hex7(nibble);

  // seg/dp only move on the edge that advances idx, which is also the edge that darkens an
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 2'd3;
      cnt       <= 16'd0;
      shadow    <= 16'd0;
      shadow_dp <= 4'd0;
      an        <= 4'b1111;
      seg       <= 7'b1111111;
      dp        <= 1'b1;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      shadow    <= shadow_nxt;
      shadow_dp <= shadow_dp_nxt;
      an        <= an_nxt;
      if (tick) begin
        seg <= seg_nxt;
        dp  <= ~shadow_dp_nxt[idx_nxt];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
`timescale 1ns/1ps
// tb_seven_seg_scan : random scan-rate/value stimulus against an event-level display model.
module tb_seven_seg_scan;

  localparam int B = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_1khz = 1'b0;
  logic        en = 1'b1;
  logic [15:0] value = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  seven_seg_scan #(.BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .clk_1khz(clk_1khz), .en(en),
    .value(value), .dp_in(dp_in), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int hp_min = 60;
  int hp_max = 60;
  int phase = 0;
  int run_len = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input logic [15:0] v, input int d);
    logic [3:0] nib;
    nib = 4'(v >> (4 * d));
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4 * d)) == 16'd0) return 7'b1111111;
`endif
    return glyph[nib];
  endfunction

  // Display model: a tick takes effect three edges after clk_1khz is first seen high,
  // then the display is dark for B cycles and lit until the next tick.
  bit         h0 = 0, h1 = 0, h2 = 0;
  int         m_idx = 3;
  logic [15:0] m_shadow = 16'h0;
  logic [3:0]  m_sdp = 4'h0;
  bit         m_started = 0;
  int         m_dark = 0;
  logic [3:0] m_an = 4'hF;
  logic [6:0] m_seg = 7'h7F;
  logic       m_dp = 1'b1;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        h0 = 0; h1 = 0; h2 = 0;
        m_idx = 3; m_shadow = 16'h0; m_sdp = 4'h0;
        m_started = 0; m_dark = 0;
        m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        if (h1 && !h2) begin
          m_idx = (m_idx + 1) % 4;
          if (m_idx == 0) begin
            m_shadow = value;
            m_sdp    = dp_in;
          end
          m_seg     = digit_seg(m_shadow, m_idx);
          m_dp      = ~m_sdp[m_idx];
          m_dark    = B;
          m_started = 1;
        end else if (m_dark > 0) begin
          m_dark = m_dark - 1;
        end
        m_an = (m_started && m_dark == 0 && en) ? 4'(~(4'b0001 << m_idx)) : 4'hF;
        h2 = h1; h1 = h0; h0 = clk_1khz;
      end
    end
  end

  initial begin
    forever begin
      repeat ($urandom_range(hp_max, hp_min)) @(negedge clk);
      clk_1khz = ~clk_1khz;
    end
  end

  // Per-cycle compare against the model, plus literal expectations in directed phases
  initial begin
    logic [6:0] lit_seg;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("an_seg_dp", {an, seg, dp}, {m_an, m_seg, m_dp});
        if (phase == 1) begin
          if (an != 4'hF) begin
            run_len++;
            case (an)
              4'b1110: lit_seg = 7'b0001110;
              4'b1101: lit_seg = 7'b0001000;
              4'b1011: lit_seg = 7'b0100100;
              4'b0111: lit_seg = 7'b1111001;
              default: lit_seg = 7'bxxxxxxx;
            endcase
            check("hex_12AF_seg", seg, lit_seg);
            check("dp_digit2", dp, (an == 4'b1011) ? 1'b0 : 1'b1);
          end else if (run_len > 0) begin
            check("lit_window_len", run_len, 2 * 60 - B);
            run_len = 0;
          end
        end else begin
          run_len = 0;
        end
        if ((phase == 2 || phase == 3) && an != 4'hF) begin
          if (an == 4'b1110)
            lit_seg = (phase == 2) ? 7'b1111000 : 7'b1000000;
          else
`ifdef SEG_LEADING_ZERO_BLANK_EN
            lit_seg = 7'b1111111;
`else
            lit_seg = 7'b1000000;
`endif
          check("leading_zero_seg", seg, lit_seg);
          check("leading_zero_dp", dp, 1'b1);
        end
      end
    end
  end

  initial begin
    int w;
    rst   = 1'b1;
    value = 16'h12AF;
    dp_in = 4'b0100;
    en    = 1'b1;
    phase = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_an", an, 4'hF);
    check("reset_seg", seg, 7'h7F);
    check("reset_dp", dp, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (1300) @(posedge clk);
    #2 phase = 0;

    @(negedge clk);
    value = 16'h0007;
    dp_in = 4'h0;
    repeat (1000) @(posedge clk);
    #2 phase = 2;
    repeat (600) @(posedge clk);
    #2 phase = 0;
    @(negedge clk);
    value = 16'h0000;
    repeat (1000) @(posedge clk);
    #2 phase = 3;
    repeat (600) @(posedge clk);
    #2 phase = 0;

    hp_min = 3;
    hp_max = 90;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(80, 1)) @(negedge clk);
      value = 16'($urandom);
      dp_in = 4'($urandom);
      if ($urandom_range(3, 0) == 0) en = ~en;
    end
    @(negedge clk);
    en     = 1'b1;
    hp_min = 60;
    hp_max = 60;

    w = 0;
    while (an == 4'hF && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("lit_before_reset", {31'd0, an != 4'hF}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_an", an, 4'hF);
    check("async_reset_seg", seg, 7'h7F);
    check("async_reset_dp", dp, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    w = 0;
    while (an == 4'hF && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("first_digit_after_reset", an, 4'b1110);
    repeat (600) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
